// File: rtl/scpu_pkg.sv
// Shared definitions for the single-cycle CPU fetch path and its controller.
// Holds next-PC select encodings and the fetch FSM state type.
// No logic; imported by scpu_npc and scpu_fetch.
package scpu_pkg;

    // Next-PC select driven by the controller on the branch bus
    localparam logic [1:0] BR_PC4    = 2'b00;
    localparam logic [1:0] BR_OFFSET = 2'b01;
    localparam logic [1:0] BR_JUMP   = 2'b10;
    localparam logic [1:0] BR_REG    = 2'b11;

    // Fetch FSM: waiting on instruction memory, or holding an instruction for execution
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/scpu_npc.sv
// Next-PC computation for the fetch unit (PC+4, branch offset, jump, register).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module scpu_npc
    import scpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [1:0]  branch,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] w_pc4;
    logic [31:0] w_offset;
    logic        w_unused_opcode;

    // Opcode bits only matter to the controller, not to target formation
    assign w_unused_opcode = &{1'b0, inst[31:26]};

    // All sums wrap modulo 2^32 by construction of the 32-bit operands
    assign w_pc4    = pc + 32'd4;
    assign w_offset = {{14{inst[15]}}, inst[15:0], 2'b00};

    // Select the target; register targets get their low bits forced to word alignment
    always_comb begin
        next_pc    = w_pc4;
        misaligned = 1'b0;
        case (branch)
            BR_PC4:    next_pc = w_pc4;
            BR_OFFSET: next_pc = w_pc4 + w_offset;
            BR_JUMP:   next_pc = {w_pc4[31:28], inst[25:0], 2'b00};
            BR_REG: begin
                next_pc    = {rs_data[31:2], 2'b00};
                misaligned = (rs_data[1:0] != 2'b00);
            end
            default:   next_pc = w_pc4;
        endcase
    end

endmodule

// File: rtl/scpu_fetch.sv
// Instruction fetch unit: requests imem at pc, holds the word until the core retires it.
// Latency: one clock from imem_ready to inst_valid; one clock from exec_ack to the next request.
// Backpressure: request held indefinitely while imem_ready=0 (timeout only flags); inst held until exec_ack.
module scpu_fetch
    import scpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  branch,
    input  logic [31:0] rs_data,
    input  logic        exec_ack,
    output logic        addr_err,
    output logic        timeout,
    output logic [31:0] instret
);

    // Counter just wide enough to hold WAIT_LIMIT; it saturates there
    localparam int           CW      = $clog2(WAIT_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT_V = CW'(WAIT_LIMIT);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0]   r_pc;
    logic [31:0]   r_inst;
    logic [31:0]   r_instret;
    logic          r_addr_err;
    logic          r_timeout;
    logic [CW-1:0] r_wait_cnt;

    logic          w_fetch_done;
    logic          w_retire;
    logic [CW-1:0] w_wait_inc;
    logic [31:0]   w_next_pc;
    logic          w_misaligned;

    scpu_npc u_npc (
        .pc         (r_pc),
        .inst       (r_inst),
        .branch     (branch),
        .rs_data    (rs_data),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

    assign w_wait_inc = (r_wait_cnt == LIMIT_V) ? r_wait_cnt : r_wait_cnt + 1'b1;

    // Register the FSM state; reset always restarts a fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; stray ready/ack outside their state are ignored
    always_comb begin
        w_state_nxt  = r_state;
        imem_req     = 1'b0;
        inst_valid   = 1'b0;
        w_fetch_done = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem_req     = 1'b1;
                w_fetch_done = imem_ready;
                if (imem_ready) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                inst_valid = 1'b1;
                w_retire   = exec_ack;
                if (exec_ack) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // Datapath: latch fetched word, advance pc on retire, track wait cycles and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inst     <= 32'd0;
            r_instret  <= 32'd0;
            r_addr_err <= 1'b0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (r_state == ST_FETCH) begin
                if (w_fetch_done) begin
                    r_inst <= imem_rdata;
                end else begin
                    r_wait_cnt <= w_wait_inc;
                    if (w_wait_inc == LIMIT_V) begin
                        r_timeout <= 1'b1;
                    end
                end
            end
            if (w_retire) begin
                r_pc       <= w_next_pc;
                r_instret  <= r_instret + 32'd1;
                r_wait_cnt <= '0;
                if (w_misaligned) begin
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = r_pc + 32'd4;
    assign inst      = r_inst;
    assign addr_err  = r_addr_err;
    assign timeout   = r_timeout;
    assign instret   = r_instret;

endmodule

// File: tb/tb_scpu_fetch.sv
// Directed bench for scpu_fetch built with a short wait limit.
// Inputs change and outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_scpu_fetch;
    import scpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  branch;
    logic [31:0] rs_data;
    logic        exec_ack;
    logic        addr_err;
    logic        timeout;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    scpu_fetch #(
        .RESET_PC   (32'h0000_0000),
        .WAIT_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .branch     (branch),
        .rs_data    (rs_data),
        .exec_ack   (exec_ack),
        .addr_err   (addr_err),
        .timeout    (timeout),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge in FETCH: memory answers this cycle
    task automatic fetch_now(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    // Called at a falling edge in EXEC: retire with the given select
    task automatic exec_now(input logic [1:0] sel, input logic [31:0] rs);
        exec_ack = 1'b1;
        branch   = sel;
        rs_data  = rs;
        @(negedge clk);
        exec_ack = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        imem_rdata = 32'd0;
        imem_ready = 1'b0;
        branch     = BR_PC4;
        rs_data    = 32'd0;
        exec_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_req",      {31'd0, imem_req},   32'd1);
        check("rst_valid",    {31'd0, inst_valid}, 32'd0);
        check("rst_pc",       pc,                  32'h0000_0000);
        check("rst_inst",     inst,                32'd0);
        check("rst_instret",  instret,             32'd0);
        check("rst_flags",    {30'd0, addr_err, timeout}, 32'd0);

        // One-cycle fetch right after reset
        check("f1_addr", imem_addr, 32'h0000_0000);
        fetch_now(32'h2008_0005);
        check("f1_valid", {31'd0, inst_valid}, 32'd1);
        check("f1_req",   {31'd0, imem_req},   32'd0);
        check("f1_inst",  inst,                32'h2008_0005);
        check("f1_pc",    pc,                  32'h0000_0000);
        check("f1_pc4",   pc_plus4,            32'h0000_0004);

        // imem_ready during EXEC must not disturb the held word
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ready = 1'b0;
        check("exec_hold_inst",  inst,                32'h2008_0005);
        check("exec_hold_valid", {31'd0, inst_valid}, 32'd1);

        // Jump to 0x10 via register, then stall three cycles
        exec_now(BR_REG, 32'h0000_0010);
        check("r1_instret", instret, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("stall_req",   {31'd0, imem_req},   32'd1);
            check("stall_valid", {31'd0, inst_valid}, 32'd0);
            check("stall_addr",  imem_addr,           32'h0000_0010);
            @(negedge clk);
        end
        check("stall4_req", {31'd0, imem_req}, 32'd1);
        fetch_now(32'h1234_5678);
        check("stall_inst",    inst,                32'h1234_5678);
        check("stall_valid_o", {31'd0, inst_valid}, 32'd1);
        check("stall_no_to",   {31'd0, timeout},    32'd0);

        // Move to 0x20 and take a branch with offset -4
        exec_now(BR_REG, 32'h0000_0020);
        fetch_now(32'h1000_FFFF);
        exec_now(BR_OFFSET, 32'd0);
        check("off_addr",    imem_addr, 32'h0000_0020);
        check("off_instret", instret,   32'd3);

        // exec_ack while fetching is ignored
        exec_ack = 1'b1;
        branch   = BR_REG;
        rs_data  = 32'h0000_0040;
        @(negedge clk);
        exec_ack = 1'b0;
        check("ack_in_fetch_pc",      pc,                32'h0000_0020);
        check("ack_in_fetch_instret", instret,           32'd3);
        check("ack_in_fetch_req",     {31'd0, imem_req}, 32'd1);

        // Absolute jump within the 0x3 region
        fetch_now(32'h0000_0000);
        exec_now(BR_REG, 32'h3000_0000);
        fetch_now(32'h0800_0040);
        exec_now(BR_JUMP, 32'd0);
        check("jump_addr",     imem_addr,           32'h3000_0100);
        check("jump_no_err",   {31'd0, addr_err},   32'd0);

        // Misaligned register target
        fetch_now(32'h0000_0000);
        exec_now(BR_REG, 32'h0000_0102);
        check("reg_mis_addr", imem_addr,         32'h0000_0100);
        check("reg_mis_err",  {31'd0, addr_err}, 32'd1);

        // Wrap of pc+4 at the top of the address space
        fetch_now(32'h0000_0000);
        exec_now(BR_REG, 32'hFFFF_FFFC);
        fetch_now(32'h0000_0000);
        check("wrap_pc4", pc_plus4, 32'h0000_0000);
        exec_now(BR_PC4, 32'd0);
        check("wrap_addr",    imem_addr,         32'h0000_0000);
        check("err_sticky",   {31'd0, addr_err}, 32'd1);

        // Reset during a stall at 0x40
        fetch_now(32'h0000_0000);
        exec_now(BR_REG, 32'h0000_0040);
        check("pre_rst_instret", instret,   32'd9);
        check("pre_rst_addr",    imem_addr, 32'h0000_0040);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_addr",    imem_addr,           32'h0000_0000);
        check("mid_rst_req",     {31'd0, imem_req},   32'd1);
        check("mid_rst_valid",   {31'd0, inst_valid}, 32'd0);
        check("mid_rst_instret", instret,             32'd0);
        check("mid_rst_err",     {31'd0, addr_err},   32'd0);

        // Four-cycle stall hits the limit of 4
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("to_after3", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        check("to_after4",  {31'd0, timeout},  32'd1);
        check("to_req_held", {31'd0, imem_req}, 32'd1);
        fetch_now(32'hCAFE_0001);
        check("to_inst",   inst,             32'hCAFE_0001);
        check("to_sticky", {31'd0, timeout}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
